fpu_issue_wb: RTL

Multi-cycle issue/writeback sequencer wrapped around the combinational `fpu` in the multi-cycle RISC-V datapath. It accepts one FP request from the control unit and holds the operands stable on the `fpu` inputs for an op-dependent number of settle cycles. It then registers the result and the overflow/underflow flags and presents them to register-file writeback through a valid/ready handshake. It also maintains the sticky FP exception flags.

---
 rtl/fpu_pkg.sv | 10 +
 rtl/fpu_issue_wb_if.sv | 23 ++
 rtl/fpu_issue_wb.sv | 114 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: op encodings, sequencer state enum and sticky-flag bit positions shared by the FPU issue/writeback slice.
package fpu_pkg;
    localparam logic [1:0] FPU_OP_ADD = 2'b00;
    localparam logic [1:0] FPU_OP_SUB = 2'b01;
    localparam logic [1:0] FPU_OP_MUL = 2'b10;
    localparam logic [1:0] FPU_OP_DIV = 2'b11;
    localparam int FFLAG_OF = 1;
    localparam int FFLAG_UF = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} fpu_state_e;
endpackage

// File: rtl/fpu_issue_wb_if.sv
// fpu_issue_wb_if: request (control unit) and response (writeback) handshakes of the FPU sequencer.
interface fpu_issue_wb_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_rd;
    logic        rsp_of;
    logic        rsp_uf;
    modport master (
        output req_valid, req_a, req_b, req_op, req_rd, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_rd, rsp_of, rsp_uf
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, req_rd, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_rd, rsp_of, rsp_uf
    );
endinterface

// File: rtl/fpu_issue_wb.sv
// fpu_issue_wb: holds operands on the combinational fpu for LAT(op) cycles, then registers and hands off the result.
// Define FPU_FFLAGS_EN to make the sticky fflags register and flags_clr functional.
module fpu_issue_wb
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD = 2,
    parameter int unsigned LAT_MUL = 3,
    parameter int unsigned LAT_DIV = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_issue_wb_if.slave     bus,
    output logic [31:0]       o_fpu_a,
    output logic [31:0]       o_fpu_b,
    output logic [1:0]        o_fpu_op,
    input  logic [31:0]       i_fpu_result,
    input  logic              i_fpu_overflow,
    input  logic              i_fpu_underflow,
    input  logic              i_flags_clr,
    output logic [1:0]        o_fflags
);
    if (LAT_ADD < 1 || LAT_ADD > 15 || LAT_MUL < 1 || LAT_MUL > 15 || LAT_DIV < 1 || LAT_DIV > 15) begin : g_lat_bad
        $fatal(1, "fpu_issue_wb: LAT_ADD/LAT_MUL/LAT_DIV must be within 1..15");
    end

    fpu_state_e  r_state;
    fpu_state_e  w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_lat;
    logic [31:0] r_fpu_a;
    logic [31:0] r_fpu_b;
    logic [1:0]  r_fpu_op;
    logic [4:0]  r_rd;
    logic [31:0] r_result;
    logic        r_of;
    logic        r_uf;
    logic        w_accept;
    logic        w_capture;
    logic [1:0]  w_flags;

    // Latency comes from the incoming op, since the op register is only loaded on this same edge.
    assign w_lat = (bus.req_op == FPU_OP_MUL) ? 4'(LAT_MUL) :
                   (bus.req_op == FPU_OP_DIV) ? 4'(LAT_DIV) : 4'(LAT_ADD);
    assign w_accept  = (r_state == ST_IDLE) && bus.req_valid;
    assign w_capture = (r_state == ST_EXEC) && (r_cnt == 4'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = bus.req_valid ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_next = (r_cnt == 4'd0) ? ST_DONE : ST_EXEC;
            ST_DONE: w_next = bus.rsp_ready ? ST_IDLE : ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_flags = 2'b00;
        w_flags[FFLAG_OF] = i_fpu_overflow;
        w_flags[FFLAG_UF] = i_fpu_underflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_fpu_a  <= 32'd0;
            r_fpu_b  <= 32'd0;
            r_fpu_op <= 2'd0;
            r_rd     <= 5'd0;
            r_result <= 32'd0;
            r_of     <= 1'b0;
            r_uf     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_fpu_a  <= bus.req_a;
                r_fpu_b  <= bus.req_b;
                r_fpu_op <= bus.req_op;
                r_rd     <= bus.req_rd;
                r_cnt    <= w_lat - 4'd1;
            end else if (r_state == ST_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_result <= i_fpu_result;
                r_of     <= i_fpu_overflow;
                r_uf     <= i_fpu_underflow;
            end
        end
    end

`ifdef FPU_FFLAGS_EN
    logic [1:0] r_fflags;
    // Clear takes effect before the OR so a same-cycle capture survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fflags <= 2'b00;
        else        r_fflags <= (i_flags_clr ? 2'b00 : r_fflags) | (w_capture ? w_flags : 2'b00);
    end
    assign o_fflags = r_fflags;
`else
    assign o_fflags = 2'b00 & {2{i_flags_clr}} & w_flags;
`endif

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.rsp_valid  = (r_state == ST_DONE);
    assign bus.rsp_result = r_result;
    assign bus.rsp_rd     = r_rd;
    assign bus.rsp_of     = r_of;
    assign bus.rsp_uf     = r_uf;
    assign o_fpu_a        = r_fpu_a;
    assign o_fpu_b        = r_fpu_b;
    assign o_fpu_op       = r_fpu_op;
endmodule
